// File: rtl/alu_pkg.sv
// Opcodes, FSM states and opcode classification shared by the ALU top and its iterative engine.
// Define ALU_DIV_EN to classify DIVU/REMU as multi-cycle ops; otherwise they are illegal.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_MULU = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1100;
    localparam logic [3:0] ALU_REMU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op == ALU_MULU) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
        return op == ALU_MULU;
`endif
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: master drives operands and out_ready, slave is the ALU.
// Both directions transfer on valid & ready.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUcontrol;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUresult;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             err;

    modport master (
        output in_valid, A, B, ALUcontrol, out_ready,
        input  in_ready, out_valid, ALUresult, zero, carry, overflow, err
    );

    modport slave (
        input  in_valid, A, B, ALUcontrol, out_ready,
        output in_ready, out_valid, ALUresult, zero, carry, overflow, err
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add MULU, restoring DIVU/REMU (with ALU_DIV_EN); one bit per cycle.
// WIDTH cycles after start; done pulses with the final-iteration result presented combinationally.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // x: product accumulator / partial remainder; y: multiplier / dividend->quotient; z: multiplicand / divisor
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             last;

    assign last = (cnt_q == LAST);
    assign done = busy_q && last;

`ifdef ALU_DIV_EN
    logic [3:0]     op_q, op_d;
    logic [WIDTH:0] rem_sh;
    logic           fits;

    // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
    assign rem_sh = {x_q, y_q[WIDTH-1]};
    assign fits   = (rem_sh >= {1'b0, z_q});
    assign dz     = (op_q != ALU_MULU) && (z_q == '0);
    assign result = (op_q == ALU_DIVU) ? y_d : x_d;
`else
    logic go;

    assign go     = start && (op == ALU_MULU);
    assign dz     = 1'b0;
    assign result = x_d;
`endif

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
`ifdef ALU_DIV_EN
        op_d   = op_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            x_d    = '0;
            op_d   = op;
            if (op == ALU_MULU) begin
                y_d = b;
                z_d = a;
            end else begin
                y_d = a;
                z_d = b;
            end
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            if (last) busy_d = 1'b0;
            if (op_q == ALU_MULU) begin
                x_d = x_q + (y_q[0] ? z_q : '0);
                y_d = y_q >> 1;
                z_d = z_q << 1;
            end else begin
                x_d = fits ? (rem_sh[WIDTH-1:0] - z_q) : rem_sh[WIDTH-1:0];
                y_d = {y_q[WIDTH-2:0], fits};
            end
        end
`else
        if (go) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            x_d    = '0;
            y_d    = b;
            z_d    = a;
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            if (last) busy_d = 1'b0;
            x_d = x_q + (y_q[0] ? z_q : '0);
            y_d = y_q >> 1;
            z_d = z_q << 1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
`ifdef ALU_DIV_EN
            op_q   <= ALU_MULU;
`endif
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
`ifdef ALU_DIV_EN
            op_q   <= op_d;
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle ops in 1 cycle, MULU (and DIVU/REMU when ALU_DIV_EN) in WIDTH+1.
// Result/flags held in DONE until out_ready; in_ready in IDLE, or in DONE while out_ready is high.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             accept;
    logic             iter_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_err;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;
    logic             eng_dz;

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.ALUresult = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.err       = err_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign iter_op = is_iter_op(bus.ALUcontrol);

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && iter_op),
        .op     (bus.ALUcontrol),
        .a      (bus.A),
        .b      (bus.B),
        .done   (eng_done),
        .result (eng_result),
        .dz     (eng_dz)
    );

    // Carry is the borrow-free indication for SUB, i.e. A >= B unsigned.
    always_comb begin
        sum      = {1'b0, bus.A} + {1'b0, bus.B};
        diff     = {1'b0, bus.A} - {1'b0, bus.B};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        case (bus.ALUcontrol)
            ALU_AND: sc_res = bus.A & bus.B;
            ALU_OR:  sc_res = bus.A | bus.B;
            ALU_XOR: sc_res = bus.A ^ bus.B;
            ALU_NOR: sc_res = ~(bus.A | bus.B);
            ALU_ADD: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_res   = diff[WIDTH-1:0];
                sc_carry = ~diff[WIDTH];
                sc_ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            default:  sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        if (accept) begin
            if (iter_op) begin
                state_d = BUSY;
            end else begin
                state_d  = DONE;
                result_d = sc_res;
                zero_d   = (sc_res == '0);
                carry_d  = sc_carry;
                ovf_d    = sc_ovf;
                err_d    = sc_err;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (eng_done) begin
                        state_d  = DONE;
                        result_d = eng_result;
                        zero_d   = (eng_result == '0);
                        carry_d  = 1'b0;
                        ovf_d    = 1'b0;
                        err_d    = eng_dz;
                    end
                end
                DONE:    if (bus.out_ready) state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed vectors, randomized ops against an arithmetic model,
// latency, backpressure, back-to-back throughput and reset during a multiply.
module tb_alu_seq;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        logic [7:0]  lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected behaviour from the opcode definitions, using wide integer arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [3:0] flg, output int lat);
        longint unsigned ua, ub, s;
        longint          sa, sb, t;
        int              ia, ib;
        bit              c, v, e;
        ua = a; ub = b; ia = $signed(a); ib = $signed(b); sa = ia; sb = ib;
        res = '0; c = 0; v = 0; e = 0; lat = 1; s = 0; t = 0;
        case (op)
            4'h0: res = a & b;
            4'h1: res = a | b;
            4'h3: res = a ^ b;
            4'h4: res = ~(a | b);
            4'h2: begin
                s = ua + ub; res = s[31:0]; c = s[32];
                t = sa + sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'h6: begin
                res = a - b; c = (ua >= ub);
                t = sa - sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'h7: res = (ia < ib) ? 32'd1 : 32'd0;
            4'h8: res = (ua < ub) ? 32'd1 : 32'd0;
            4'hA: begin s = ua * ub; res = s[31:0]; lat = 33; end
`ifdef ALU_DIV_EN
            4'hC, 4'hD: begin
                lat = 33;
                if (b == 0) begin
                    e = 1;
                    res = (op == 4'hC) ? 32'hFFFF_FFFF : a;
                end else begin
                    res = (op == 4'hC) ? (a / b) : (a % b);
                end
            end
`endif
            default: e = 1;
        endcase
        flg = {(res == 0), c, v, e};
    endtask

    // Presents one op, waits for the accept edge, then for out_valid; called #1 after a clock edge.
    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic [3:0] flg, output int lat);
        int guard;
        bus.A = a; bus.B = b; bus.ALUcontrol = op; bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        res = bus.ALUresult;
        flg = {bus.zero, bus.carry, bus.overflow, bus.err};
    endtask

    task automatic settle_idle();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.A = '0; bus.B = '0; bus.ALUcontrol = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            failures++; $display("FAIL reset_handshake got in_ready/out_valid=%b want 10", {bus.in_ready, bus.out_valid});
        end
        checks++;
        if (bus.ALUresult !== 32'd0) begin
            failures++; $display("FAIL reset_result got %h want 0", bus.ALUresult);
        end
        checks++;
        if ({bus.zero, bus.carry, bus.overflow, bus.err} !== 4'b1000) begin
            failures++; $display("FAIL reset_flags got %b want 1000", {bus.zero, bus.carry, bus.overflow, bus.err});
        end
    endtask

    task automatic test_directed();
        vec_t        tbl [10];
        logic [31:0] r;
        logic [3:0]  f;
        int          l;
        tbl[0] = '{4'h2, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 4'b1100, 8'd1};
        tbl[1] = '{4'h2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0010, 8'd1};
        tbl[2] = '{4'h6, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0000, 8'd1};
        tbl[3] = '{4'h7, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000, 8'd1};
        tbl[4] = '{4'h8, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1000, 8'd1};
        tbl[5] = '{4'hA, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 4'b0000, 8'd33};
        tbl[6] = '{4'h1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0000, 8'd1};
        tbl[7] = '{4'h5, 32'h1234_5678, 32'h0000_0001, 32'd0, 4'b1001, 8'd1};
        tbl[8] = '{4'h6, 32'd5, 32'd3, 32'd2, 4'b0100, 8'd1};
        tbl[9] = '{4'h6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0110, 8'd1};
        for (int i = 0; i < 10; i++) begin
            drive_op(tbl[i].op, tbl[i].a, tbl[i].b, r, f, l);
            checks++;
            if (r !== tbl[i].res) begin
                failures++; $display("FAIL directed_res[%0d] op=%h got %h want %h", i, tbl[i].op, r, tbl[i].res);
            end
            checks++;
            if (f !== tbl[i].flg) begin
                failures++; $display("FAIL directed_flags[%0d] op=%h got %b want %b", i, tbl[i].op, f, tbl[i].flg);
            end
            checks++;
            if (l !== int'(tbl[i].lat)) begin
                failures++; $display("FAIL directed_latency[%0d] op=%h got %0d want %0d", i, tbl[i].op, l, tbl[i].lat);
            end
        end
    endtask

    task automatic test_div();
        vec_t        tbl [4];
        logic [31:0] r;
        logic [3:0]  f;
        int          l;
`ifdef ALU_DIV_EN
        tbl[0] = '{4'hC, 32'd100, 32'd7, 32'd14, 4'b0000, 8'd33};
        tbl[1] = '{4'hD, 32'd100, 32'd7, 32'd2, 4'b0000, 8'd33};
        tbl[2] = '{4'hC, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'b0001, 8'd33};
        tbl[3] = '{4'hD, 32'd5, 32'd0, 32'd5, 4'b0001, 8'd33};
`else
        tbl[0] = '{4'hC, 32'd100, 32'd7, 32'd0, 4'b1001, 8'd1};
        tbl[1] = '{4'hD, 32'd100, 32'd7, 32'd0, 4'b1001, 8'd1};
        tbl[2] = '{4'hC, 32'd5, 32'd0, 32'd0, 4'b1001, 8'd1};
        tbl[3] = '{4'hD, 32'd5, 32'd0, 32'd0, 4'b1001, 8'd1};
`endif
        for (int i = 0; i < 4; i++) begin
            drive_op(tbl[i].op, tbl[i].a, tbl[i].b, r, f, l);
            checks++;
            if ({r, f} !== {tbl[i].res, tbl[i].flg}) begin
                failures++; $display("FAIL div[%0d] op=%h got res=%h flags=%b want res=%h flags=%b",
                                     i, tbl[i].op, r, f, tbl[i].res, tbl[i].flg);
            end
            checks++;
            if (l !== int'(tbl[i].lat)) begin
                failures++; $display("FAIL div_latency[%0d] got %0d want %0d", i, l, tbl[i].lat);
            end
        end
    endtask

    task automatic test_mulu_busy();
        int          lat;
        int          ready_seen;
        logic [31:0] a, b, er;
        logic [3:0]  ef;
        int          el;
        a = $urandom; b = $urandom;
        model(4'hA, a, b, er, ef, el);
        bus.A = a; bus.B = b; bus.ALUcontrol = 4'hA; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1; ready_seen = 0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) ready_seen++;
            bus.A = $urandom; bus.B = $urandom;
            @(posedge clk); #1; lat++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (ready_seen !== 0) begin
            failures++; $display("FAIL mulu_busy_in_ready got %0d ready cycles want 0", ready_seen);
        end
        checks++;
        if (lat !== el) begin
            failures++; $display("FAIL mulu_latency got %0d want %0d", lat, el);
        end
        checks++;
        if (bus.ALUresult !== er) begin
            failures++; $display("FAIL mulu_operands_latched got %h want %h", bus.ALUresult, er);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b, r, er;
        logic [3:0]  f, ef;
        int          l, el;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            model(op, a, b, er, ef, el);
            drive_op(op, a, b, r, f, l);
            checks++;
            if ({r, f} !== {er, ef}) begin
                failures++; $display("FAIL random[%0d] op=%h a=%h b=%h got res=%h flags=%b want res=%h flags=%b",
                                     i, op, a, b, r, f, er, ef);
            end
            checks++;
            if (l !== el) begin
                failures++; $display("FAIL random_latency[%0d] op=%h got %0d want %0d", i, op, l, el);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, r, er;
        logic [3:0]  f, ef;
        int          l, el;
        settle_idle();
        bus.out_ready = 1'b0;
        a = $urandom; b = $urandom;
        model(4'h0, a, b, er, ef, el);
        drive_op(4'h0, a, b, r, f, l);
        checks++;
        if (r !== er) begin
            failures++; $display("FAIL bp_and_result got %h want %h", r, er);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.ALUresult, bus.zero, bus.carry, bus.overflow, bus.err}
                !== {1'b1, 1'b0, er, ef}) begin
                failures++; $display("FAIL bp_hold[%0d] got valid=%b ready=%b res=%h want valid=1 ready=0 res=%h",
                                     c, bus.out_valid, bus.in_ready, bus.ALUresult, er);
            end
        end
        a = $urandom; b = $urandom;
        model(4'h3, a, b, er, ef, el);
        bus.A = a; bus.B = b; bus.ALUcontrol = 4'h3; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.ALUresult} !== {1'b1, er}) begin
            failures++; $display("FAIL bp_back_to_back got valid=%b res=%h want valid=1 res=%h",
                                 bus.out_valid, bus.ALUresult, er);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [8];
        logic [3:0]  sc  [8];
        logic [31:0] exp_r [8];
        logic [3:0]  exp_f [8];
        logic [31:0] a, b;
        int          el;
        sc = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8};
        settle_idle();
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                checks++;
                if ({bus.out_valid, bus.ALUresult, bus.zero, bus.carry, bus.overflow, bus.err}
                    !== {1'b1, exp_r[i-1], exp_f[i-1]}) begin
                    failures++; $display("FAIL b2b[%0d] op=%h got valid=%b res=%h want valid=1 res=%h",
                                         i - 1, ops[i-1], bus.out_valid, bus.ALUresult, exp_r[i-1]);
                end
            end
            if (i < 8) begin
                ops[i] = sc[$urandom_range(0, 7)];
                a = $urandom; b = $urandom;
                model(ops[i], a, b, exp_r[i], exp_f[i], el);
                bus.A = a; bus.B = b; bus.ALUcontrol = ops[i]; bus.in_valid = 1'b1;
                #1;
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    failures++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, bus.in_ready);
                end
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] r;
        logic [3:0]  f;
        int          l;
        int          spurious;
        settle_idle();
        bus.A = 32'h0001_0001; bus.B = 32'h0001_0001; bus.ALUcontrol = 4'hA; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.ALUresult, bus.zero, bus.carry, bus.overflow, bus.err}
            !== {1'b0, 1'b1, 32'd0, 4'b1000}) begin
            failures++; $display("FAIL rst_mid_busy got valid=%b ready=%b res=%h flags=%b want 0 1 0 1000",
                                 bus.out_valid, bus.in_ready, bus.ALUresult,
                                 {bus.zero, bus.carry, bus.overflow, bus.err});
        end
        rst = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++; $display("FAIL rst_discard got %0d valid cycles want 0", spurious);
        end
        drive_op(4'h1, 32'h0000_00F0, 32'h0000_000F, r, f, l);
        checks++;
        if ({r, f} !== {32'h0000_00FF, 4'b0000} || l !== 1) begin
            failures++; $display("FAIL rst_then_or got res=%h flags=%b lat=%0d want res=000000ff flags=0000 lat=1",
                                 r, f, l);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div();
        test_mulu_busy();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
